// File: rtl/mult_rr_scheduler_if.sv
// Client and multiplier pins of the round-robin multiplier scheduler.
// The scheduler uses the slave modport; client and multiplier logic use master.
interface mult_rr_scheduler_if #(
  parameter int L_WORD = 4
);
  logic [3:0]            req;
  logic [4*L_WORD-1:0]   a_bus;
  logic [4*L_WORD-1:0]   b_bus;
  logic [3:0]            gnt;
  logic [3:0]            done;
  logic [2*L_WORD-1:0]   result;
  logic                  err;
  logic                  busy;
  logic [L_WORD-1:0]     mul_word1;
  logic [L_WORD-1:0]     mul_word2;
  logic                  mul_start;
  logic                  mul_ready;
  logic [2*L_WORD-1:0]   mul_final_product;

  modport slave (
    input  req, a_bus, b_bus, mul_ready, mul_final_product,
    output gnt, done, result, err, busy, mul_word1, mul_word2, mul_start
  );

  modport master (
    output req, a_bus, b_bus, mul_ready, mul_final_product,
    input  gnt, done, result, err, busy, mul_word1, mul_word2, mul_start
  );
endinterface

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one shift-add multiplier among four requesters.
// Grant 1 cycle after req, start 1 cycle later; stalls on mul_ready, aborts with err after TIMEOUT cycles.
module mult_rr_scheduler #(
  parameter int L_WORD  = 4,
  parameter int TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst,
  mult_rr_scheduler_if.slave bus
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [1:0]            rr_ptr;
  logic [1:0]            win;
  logic [1:0]            pick;
  logic                  pick_vld;
  logic [CW-1:0]         tmo_cnt;
  logic [3:0]            gnt_q;
  logic [3:0]            done_q;
  logic [2*L_WORD-1:0]   result_q;
  logic                  err_q;
  logic                  busy_q;
  logic                  start_q;
  logic [L_WORD-1:0]     word1_q;
  logic [L_WORD-1:0]     word2_q;

  // Scan from the farthest offset down so the nearest requester after rr_ptr wins.
  always_comb begin
    pick     = rr_ptr;
    pick_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[rr_ptr + 2'(k)]) begin
        pick     = rr_ptr + 2'(k);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      win      <= '0;
      tmo_cnt  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      word1_q  <= '0;
      word2_q  <= '0;
    end else begin
      done_q <= '0;
      case (state)
        IDLE: begin
          if (pick_vld && bus.mul_ready) begin
            gnt_q   <= 4'b0001 << pick;
            win     <= pick;
            word1_q <= bus.a_bus[int'(pick)*L_WORD +: L_WORD];
            word2_q <= bus.b_bus[int'(pick)*L_WORD +: L_WORD];
            tmo_cnt <= '0;
            busy_q  <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE, RUN: begin
          if (tmo_cnt == CW'(TIMEOUT - 1)) begin
            result_q <= '0;
            err_q    <= 1'b1;
            start_q  <= 1'b0;
            done_q   <= gnt_q;
            state    <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (state == ISSUE) begin
              // Ready falling is the multiplier's acknowledgement of start.
              if (!bus.mul_ready) begin
                start_q <= 1'b0;
                state   <= RUN;
              end else begin
                start_q <= 1'b1;
              end
            end else if (bus.mul_ready) begin
              result_q <= bus.mul_final_product;
              err_q    <= 1'b0;
              done_q   <= gnt_q;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          gnt_q  <= '0;
          busy_q <= 1'b0;
          rr_ptr <= win + 2'd1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.mul_start = start_q;
  assign bus.mul_word1 = word1_q;
  assign bus.mul_word2 = word2_q;
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Bench for mult_rr_scheduler: behavioural multiplier, transaction-level round-robin model,
// directed scenarios with literal expectations followed by a randomized phase.
module tb_mult_rr_scheduler;
  localparam int L  = 4;
  localparam int TO = 64;

  logic clk;
  logic rst;

  mult_rr_scheduler_if #(.L_WORD(L)) bus ();

  mult_rr_scheduler #(.L_WORD(L), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_err = 0;
  int n_chk = 0;

  // Multiplier behaviour: accepts start while ready, drops ready, returns after a random latency.
  bit stuck;
  int lat_lo, lat_hi;
  logic [L-1:0] m_a, m_b;
  bit m_busy;
  int m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mul_ready         <= 1'b1;
      bus.mul_final_product <= '0;
      m_busy                <= 1'b0;
      m_cnt                 <= 0;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        bus.mul_ready         <= 1'b1;
        bus.mul_final_product <= {{L{1'b0}}, m_a} * {{L{1'b0}}, m_b};
        m_busy                <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (bus.mul_start && bus.mul_ready && !stuck) begin
      m_a           <= bus.mul_word1;
      m_b           <= bus.mul_word2;
      bus.mul_ready <= 1'b0;
      m_busy        <= 1'b1;
      m_cnt         <= int'($urandom_range(lat_hi, lat_lo));
    end
  end

  // Reference model state: operands each requester presents, pointer, in-flight job.
  logic [L-1:0] op_a [4];
  logic [L-1:0] op_b [4];
  bit           hold [4];
  bit           rnd_mode;
  int           exp_ptr, cur_w, cyc;
  bit           pending, exp_err, prev_idle;
  longint       exp_res;
  logic [3:0]   prev_gnt, prev_req, prev_done, gmask;
  int           wait_cnt [4];
  int           comp_w [$];
  longint       comp_res [$];
  int           comp_err [$];

  task automatic check(input bit ok, input string name, input longint act, input longint req_v);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req_v, $time);
    end
  endtask

  function automatic int q_w(input int i);
    return (i < comp_w.size()) ? comp_w[i] : -1;
  endfunction
  function automatic longint q_res(input int i);
    return (i < comp_res.size()) ? comp_res[i] : -1;
  endfunction
  function automatic int q_err(input int i);
    return (i < comp_err.size()) ? comp_err[i] : -1;
  endfunction

  task automatic set_op(input int i, input int a, input int b);
    op_a[i] = L'(a);
    op_b[i] = L'(b);
    bus.a_bus[i*L +: L] = L'(a);
    bus.b_bus[i*L +: L] = L'(b);
  endtask

  task automatic monitor();
    int w;
    int mx;
    if (rst) begin
      exp_ptr = 0; pending = 0; prev_idle = 0;
      prev_gnt = '0; prev_req = '0; prev_done = '0;
      for (int j = 0; j < 4; j++) wait_cnt[j] = 0;
      return;
    end
    check(bus.busy == (bus.gnt != 4'b0), "busy_vs_gnt", bus.busy, bus.gnt != 4'b0);
    check(!bus.mul_start || (bus.gnt != 4'b0 && bus.done == 4'b0), "start_window", bus.mul_start, 0);
    if (prev_done != 4'b0)
      check(bus.done == 4'b0 && bus.gnt == 4'b0 && !bus.busy, "idle_after_done",
            {bus.done, bus.gnt, bus.busy}, 0);
    for (int j = 0; j < 4; j++) if (!bus.req[j]) wait_cnt[j] = 0;

    if (prev_gnt == 4'b0 && bus.gnt != 4'b0) begin
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && prev_req[(exp_ptr + k) % 4]) w = (exp_ptr + k) % 4;
      check(w >= 0 && bus.gnt == 4'(1 << w), "grant_winner", bus.gnt, (w < 0) ? 0 : (1 << w));
      pending = (w >= 0);
      cur_w   = (w < 0) ? 0 : w;
      gmask   = prev_req;
      exp_res = longint'(op_a[cur_w]) * longint'(op_b[cur_w]);
      exp_err = stuck;
      if (stuck) exp_res = 0;
      cyc     = 0;
    end else if (prev_idle && prev_req != 4'b0) begin
      check(bus.gnt != 4'b0, "grant_missing", bus.gnt, prev_req);
    end

    if (pending) begin
      cyc++;
      check(bus.gnt == 4'(1 << cur_w) && bus.mul_word1 == op_a[cur_w] && bus.mul_word2 == op_b[cur_w],
            "gnt_operands_hold", {bus.gnt, bus.mul_word1, bus.mul_word2},
            {4'(1 << cur_w), op_a[cur_w], op_b[cur_w]});
    end

    if (bus.done != 4'b0) begin
      check(pending && bus.done == bus.gnt, "done_target", bus.done, pending ? (1 << cur_w) : 0);
      check(longint'(bus.result) == exp_res, "result", bus.result, exp_res);
      check(bus.err == exp_err, "err", bus.err, exp_err);
      check(exp_err ? (cyc == TO + 1) : (cyc <= TO), "op_duration", cyc, exp_err ? TO + 1 : TO);
      mx = 0;
      for (int j = 0; j < 4; j++) begin
        if (j == cur_w) wait_cnt[j] = 0;
        else if (gmask[j] && bus.req[j]) wait_cnt[j]++;
        if (wait_cnt[j] > mx) mx = wait_cnt[j];
      end
      check(mx <= 3, "starvation", mx, 3);
      comp_w.push_back(cur_w);
      comp_res.push_back(longint'(bus.result));
      comp_err.push_back(int'(bus.err));
      exp_ptr = (cur_w + 1) % 4;
      pending = 0;
    end

    prev_gnt  = bus.gnt;
    prev_req  = bus.req;
    prev_done = bus.done;
    prev_idle = !bus.busy && bus.gnt == 4'b0 && bus.mul_ready;
  endtask

  // Requesters drop req on their done pulse unless held; random mode raises and drops at will.
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (bus.done[i] && !hold[i] && (!rnd_mode || $urandom_range(1, 0) == 0))
        bus.req[i] = 1'b0;
      if (rnd_mode) begin
        if (!bus.req[i] && !bus.gnt[i] && $urandom_range(3, 0) == 0) begin
          set_op(i, int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
          bus.req[i] = 1'b1;
        end else if (bus.req[i] && bus.gnt[i] && !bus.done[i] && $urandom_range(15, 0) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic wait_done(input int n, input int budget);
    int target;
    int k;
    target = comp_w.size() + n;
    k = 0;
    while (comp_w.size() < target && k < budget) begin
      tick();
      k++;
    end
    check(comp_w.size() >= target, "wait_done", comp_w.size(), target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int exp4 [4];
    int bnd [4][3];
    bit found;

    exp4 = '{6, 9, 12, 15};
    bnd  = '{'{15, 15, 225}, '{0, 9, 0}, '{9, 0, 0}, '{1, 1, 1}};
    rst = 1'b1;
    stuck = 1'b0; rnd_mode = 1'b0; lat_lo = 0; lat_hi = 6;
    bus.req = '0; bus.a_bus = '0; bus.b_bus = '0;
    for (int i = 0; i < 4; i++) begin
      hold[i] = 1'b0; op_a[i] = '0; op_b[i] = '0; wait_cnt[i] = 0;
    end
    tick();
    tick();
    check(bus.gnt == 4'b0 && bus.done == 4'b0, "reset_gnt_done", {bus.gnt, bus.done}, 0);
    check(bus.result == '0 && !bus.err, "reset_result_err", {bus.result, bus.err}, 0);
    check(!bus.busy && !bus.mul_start, "reset_busy_start", {bus.busy, bus.mul_start}, 0);
    check(bus.mul_word1 == '0 && bus.mul_word2 == '0, "reset_words", {bus.mul_word1, bus.mul_word2}, 0);
    rst = 1'b0;
    tick();

    // All four at once from pointer 0.
    base = comp_w.size();
    for (int i = 0; i < 4; i++) set_op(i, i + 2, 3);
    bus.req = 4'b1111;
    wait_done(4, 400);
    for (int i = 0; i < 4; i++) begin
      check(q_w(base + i) == i, "all4_order", q_w(base + i), i);
      check(q_res(base + i) == exp4[i], "all4_result", q_res(base + i), exp4[i]);
    end

    // Pointer back at 0: requester 1 beats requester 3.
    base = comp_w.size();
    set_op(1, 4, 4); set_op(3, 5, 5);
    bus.req = 4'b1010;
    wait_done(2, 200);
    check(q_w(base) == 1 && q_res(base) == 16, "ptr_wrap_first", q_w(base), 1);
    check(q_w(base + 1) == 3 && q_res(base + 1) == 25, "ptr_wrap_second", q_w(base + 1), 3);

    base = comp_w.size();
    set_op(0, 3, 5);
    bus.req = 4'b0001;
    wait_done(1, 200);
    check(q_w(base) == 0 && q_res(base) == 15 && q_err(base) == 0, "single_3x5", q_res(base), 15);

    for (int t = 0; t < 4; t++) begin
      base = comp_w.size();
      set_op(3, bnd[t][0], bnd[t][1]);
      bus.req[3] = 1'b1;
      wait_done(1, 200);
      check(q_res(base) == bnd[t][2] && q_err(base) == 0, "boundary_product", q_res(base), bnd[t][2]);
    end

    // Requesters 0 and 2 held continuously from pointer 0.
    base = comp_w.size();
    hold[0] = 1'b1; hold[2] = 1'b1;
    set_op(0, 6, 7); set_op(2, 11, 13);
    bus.req = 4'b0101;
    wait_done(6, 600);
    bus.req = 4'b0000;
    hold[0] = 1'b0; hold[2] = 1'b0;
    for (int k = 0; k < 6; k++)
      check(q_w(base + k) == ((k % 2) * 2) && q_res(base + k) == ((k % 2) ? 143 : 42),
            "fair_alternate", q_w(base + k), (k % 2) * 2);

    // Multiplier never acknowledges start.
    base = comp_w.size();
    stuck = 1'b1;
    set_op(1, 5, 5);
    bus.req = 4'b0010;
    wait_done(1, TO + 50);
    check(q_err(base) == 1 && q_res(base) == 0, "timeout_err", q_res(base), 0);
    stuck = 1'b0;
    set_op(1, 2, 7);
    bus.req = 4'b0010;
    wait_done(1, 200);
    check(q_err(base + 1) == 0 && q_res(base + 1) == 14, "after_timeout", q_res(base + 1), 14);

    // Async reset while the multiplier is computing.
    lat_lo = 6; lat_hi = 6;
    set_op(0, 13, 11);
    bus.req = 4'b0001;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      tick();
      found = bus.busy && !bus.mul_start && !bus.mul_ready && bus.done == 4'b0;
    end
    check(found, "reach_run", found, 1);
    #2;
    rst = 1'b1;
    bus.req = 4'b0000;
    #1;
    check(bus.gnt == 4'b0 && !bus.busy && !bus.mul_start, "async_reset_clear",
          {bus.gnt, bus.busy, bus.mul_start}, 0);
    check(bus.done == 4'b0 && bus.result == '0, "async_reset_no_done", {bus.done, bus.result}, 0);
    tick();
    tick();
    rst = 1'b0;
    lat_lo = 0; lat_hi = 6;
    base = comp_w.size();
    set_op(2, 7, 6);
    bus.req = 4'b0100;
    wait_done(1, 200);
    check(q_w(base) == 2 && q_res(base) == 42, "post_reset_op", q_res(base), 42);

    rnd_mode = 1'b1;
    wait_done(150, 30000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
